// File: rtl/ram_fifo_bridge_pkg.sv
// rtl/ram_fifo_bridge_pkg.sv - shared state encoding and line/word geometry for the RAM FIFO bridge
package ram_fifo_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR       = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_PUSH  = 2'd3
  } state_t;

  localparam int DEF_ADDR_SIZE      = 13;
  localparam int DEF_CASH_STR_WIDTH = 64;
  localparam int DEF_WORD_W         = 16;

  function automatic int beats_of(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // A single-beat line still gets a 1-bit counter so vectors never collapse to zero width.
  function automatic int beat_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ram_fifo_bridge.sv
// rtl/ram_fifo_bridge.sv - moves one cache line between the data FIFOs and a synchronous single-port SRAM
module ram_fifo_bridge
  import ram_fifo_bridge_pkg::*;
#(
  parameter int  ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int  CASH_STR_WIDTH = DEF_CASH_STR_WIDTH,
  parameter int  WORD_W         = DEF_WORD_W,
  localparam int BEATS          = beats_of(CASH_STR_WIDTH, WORD_W),
  localparam int BEAT_W         = beat_w_of(BEATS),
  localparam int MEM_AW         = ADDR_SIZE + BEAT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ram_avalid,
  input  logic [ADDR_SIZE-1:0] ram_addr,
  input  logic                 ram_rnw,
  input  logic                 wf_empty,
  input  logic [WORD_W-1:0]    wf_rdata,
  output logic                 wf_rd,
  input  logic                 rf_full,
  output logic                 rf_wr,
  output logic [WORD_W-1:0]    rf_wdata,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic                 err_overflow
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t               r_state;
  logic [BEAT_W-1:0]    r_beat;
  logic [ADDR_SIZE-1:0] r_line_addr;
  logic                 r_hold_valid;
  logic [WORD_W-1:0]    r_hold_data;
  logic                 r_err_overflow;

  logic                 w_last_beat;
  logic [BEAT_W-1:0]    w_next_beat;
  logic                 w_wr_xfer;
  logic                 w_rd_push;

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_next_beat = w_last_beat ? '0 : r_beat + 1'b1;
  assign w_wr_xfer   = (r_state == S_WR) && !wf_empty;
  assign w_rd_push   = (r_state == S_RD_PUSH) && !rf_full;

  assign wf_rd        = w_wr_xfer;
  assign mem_we       = w_wr_xfer;
  assign mem_re       = (r_state == S_RD_ISSUE);
  assign rf_wr        = w_rd_push;
  assign mem_addr     = {r_line_addr, r_beat};
  assign mem_wdata    = wf_rdata;
  // Once a word has been parked by backpressure the SRAM output is stale, so the hold copy wins.
  assign rf_wdata     = r_hold_valid ? r_hold_data : mem_rdata;
  assign busy         = (r_state != S_IDLE);
  assign err_overflow = r_err_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_beat         <= '0;
      r_line_addr    <= '0;
      r_hold_valid   <= 1'b0;
      r_hold_data    <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (ram_avalid && (r_state != S_IDLE)) begin
        r_err_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (ram_avalid) begin
            r_line_addr <= ram_addr;
            r_beat      <= '0;
            r_state     <= ram_rnw ? S_RD_ISSUE : S_WR;
          end
        end
        S_WR: begin
          if (w_wr_xfer) begin
            r_beat <= w_next_beat;
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_PUSH;
        end
        S_RD_PUSH: begin
          if (!rf_full) begin
            r_hold_valid <= 1'b0;
            r_beat       <= w_next_beat;
            r_state      <= w_last_beat ? S_IDLE : S_RD_ISSUE;
          end else if (!r_hold_valid) begin
            r_hold_data  <= mem_rdata;
            r_hold_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_bridge.sv
// tb/tb_ram_fifo_bridge.sv - directed self-checking bench for ram_fifo_bridge
module tb_ram_fifo_bridge;

  logic        clk;
  logic        reset;
  logic        ram_avalid;
  logic [12:0] ram_addr;
  logic        ram_rnw;
  logic        wf_empty;
  logic [15:0] wf_rdata;
  logic        wf_rd;
  logic        rf_full;
  logic        rf_wr;
  logic [15:0] rf_wdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err_overflow;

  int checks   = 0;
  int failures = 0;

  ram_fifo_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .ram_avalid   (ram_avalid),
    .ram_addr     (ram_addr),
    .ram_rnw      (ram_rnw),
    .wf_empty     (wf_empty),
    .wf_rdata     (wf_rdata),
    .wf_rd        (wf_rd),
    .rf_full      (rf_full),
    .rf_wr        (rf_wr),
    .rf_wdata     (rf_wdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, output poisoned when no read was issued.
  logic [15:0] sram [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? sram[mem_addr] : 16'hDEAD;
  end

  // Show-ahead write-data FIFO model.
  logic [15:0] wf_mem [0:15];
  int          wf_wp = 0;
  int          wf_rp = 0;
  logic        wf_block = 1'b0;

  always @(posedge clk) begin
    if (wf_rd) wf_rp <= wf_rp + 1;
  end

  assign wf_empty = (wf_rp == wf_wp) || wf_block;
  assign wf_rdata = wf_mem[wf_rp[3:0]];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_wf(input logic [15:0] d);
    wf_mem[wf_wp[3:0]] = d;
    wf_wp = wf_wp + 1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({busy, wf_rd, mem_we, mem_re, rf_wr, err_overflow} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=000000", {busy, wf_rd, mem_we, mem_re, rf_wr, err_overflow});
    end
    checks++;
    if (mem_addr !== 15'h0) begin
      failures++;
      $display("FAIL reset_mem_addr got=%h want=0000", mem_addr);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_line();
    logic [15:0] exp_d [4];
    logic [14:0] exp_a;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    for (int i = 0; i < 4; i++) push_wf(exp_d[i]);
    ram_avalid = 1'b1; ram_rnw = 1'b0; ram_addr = 13'h0005;
    step();
    ram_avalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      exp_a = {13'h0005, 2'(b)};
      checks++;
      if (mem_we !== 1'b1 || wf_rd !== 1'b1 || mem_addr !== exp_a || mem_wdata !== exp_d[b]) begin
        failures++;
        $display("FAIL write_beat%0d got we=%b rd=%b addr=%h data=%h want we=1 rd=1 addr=%h data=%h",
                 b, mem_we, wf_rd, mem_addr, mem_wdata, exp_a, exp_d[b]);
      end
      step();
    end
    #1;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL write_done got busy=%b we=%b want busy=0 we=0", busy, mem_we);
    end
    checks++;
    if (sram[15'h0017] !== 16'h4444) begin
      failures++;
      $display("FAIL write_sram_last got=%h want=4444", sram[15'h0017]);
    end
  endtask

  task automatic test_read_line(input logic [12:0] line, input logic [15:0] d0);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) preload({line, 2'(i)}, d0 + 16'(i));
    ram_avalid = 1'b1; ram_rnw = 1'b1; ram_addr = line;
    step();
    ram_avalid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      #1;
      if (rf_wr === 1'b1) begin
        checks++;
        if (rf_wdata !== d0 + 16'(n) || c != 2 + 2 * n) begin
          failures++;
          $display("FAIL read_push%0d got data=%h cycle=%0d want data=%h cycle=%0d",
                   n, rf_wdata, c, d0 + 16'(n), 2 + 2 * n);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL read_count got pushes=%0d busy=%b want pushes=4 busy=0", n, busy);
    end
  endtask

  task automatic test_write_starvation();
    int n;
    int bad;
    n = 0; bad = 0;
    for (int i = 0; i < 4; i++) push_wf(16'h5A00 + 16'(i));
    ram_avalid = 1'b1; ram_rnw = 1'b0; ram_addr = 13'h000A;
    step();
    ram_avalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      wf_block = (c % 2 == 0);
      #1;
      if (wf_rd === 1'b1 && wf_empty === 1'b1) bad++;
      if (mem_we === 1'b1) begin
        checks++;
        if (mem_addr !== {13'h000A, 2'(n)} || mem_wdata !== 16'h5A00 + 16'(n) || c != 2 * n + 1) begin
          failures++;
          $display("FAIL starve_beat%0d got addr=%h data=%h cycle=%0d want addr=%h data=%h cycle=%0d",
                   n, mem_addr, mem_wdata, c, {13'h000A, 2'(n)}, 16'h5A00 + 16'(n), 2 * n + 1);
        end
        n++;
      end
      step();
    end
    wf_block = 1'b0;
    checks++;
    if (n != 4 || bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL starve_summary got writes=%0d rd_while_empty=%0d busy=%b want 4 0 0", n, bad, busy);
    end
  endtask

  task automatic test_read_backpressure();
    int n;
    int bad;
    int exp_c [4];
    n = 0; bad = 0;
    exp_c[0] = 2; exp_c[1] = 9; exp_c[2] = 11; exp_c[3] = 13;
    for (int i = 0; i < 4; i++) preload({13'h000C, 2'(i)}, 16'h00B0 + 16'(i));
    ram_avalid = 1'b1; ram_rnw = 1'b1; ram_addr = 13'h000C;
    step();
    ram_avalid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      rf_full = (c >= 4 && c <= 8);
      #1;
      if (rf_wr === 1'b1) begin
        if (rf_full) bad++;
        checks++;
        if (n > 3 || rf_wdata !== 16'h00B0 + 16'(n) || c != exp_c[n & 3]) begin
          failures++;
          $display("FAIL bp_push%0d got data=%h cycle=%0d want data=%h cycle=%0d",
                   n, rf_wdata, c, 16'h00B0 + 16'(n), exp_c[n & 3]);
        end
        n++;
      end
      step();
    end
    rf_full = 1'b0;
    checks++;
    if (n != 4 || bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_summary got pushes=%0d push_while_full=%0d busy=%b want 4 0 0", n, bad, busy);
    end
  endtask

  task automatic test_overflow();
    int n;
    int n_re;
    int n_we;
    int rp0;
    n = 0; n_re = 0; n_we = 0;
    preload(15'h007C, 16'h0000);
    for (int i = 0; i < 4; i++) preload({13'h0010, 2'(i)}, 16'h00C0 + 16'(i));
    push_wf(16'hEEEE);
    rp0 = wf_rp;
    ram_avalid = 1'b1; ram_rnw = 1'b1; ram_addr = 13'h0010;
    step();
    for (int c = 1; c <= 12; c++) begin
      ram_avalid = (c == 1 || c == 8);
      ram_rnw    = (c == 8);
      ram_addr   = (c == 1) ? 13'h001F : 13'h0011;
      #1;
      if (mem_re === 1'b1) n_re++;
      if (mem_we === 1'b1) n_we++;
      if (rf_wr === 1'b1) begin
        checks++;
        if (rf_wdata !== 16'h00C0 + 16'(n) || c != 2 + 2 * n) begin
          failures++;
          $display("FAIL ovf_push%0d got data=%h cycle=%0d want data=%h cycle=%0d",
                   n, rf_wdata, c, 16'h00C0 + 16'(n), 2 + 2 * n);
        end
        n++;
      end
      step();
    end
    ram_avalid = 1'b0;
    #1;
    checks++;
    if (err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag got=%b want=1", err_overflow);
    end
    checks++;
    if (n != 4 || n_re != 4 || n_we != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_activity got pushes=%0d reads=%0d writes=%0d busy=%b want 4 4 0 0", n, n_re, n_we, busy);
    end
    checks++;
    if (wf_rp != rp0 || sram[15'h007C] !== 16'h0000) begin
      failures++;
      $display("FAIL ovf_dropped got pops=%0d sram7c=%h want pops=0 sram7c=0000", wf_rp - rp0, sram[15'h007C]);
    end
    step();
    wf_wp = wf_rp;
  endtask

  task automatic test_reset_mid_write();
    int bad;
    bad = 0;
    #1;
    checks++;
    if (err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL sticky_ovf got=%b want=1", err_overflow);
    end
    preload(15'h000E, 16'h0000);
    preload(15'h000F, 16'h0000);
    for (int i = 0; i < 4; i++) push_wf(16'h7000 + 16'(i));
    ram_avalid = 1'b1; ram_rnw = 1'b0; ram_addr = 13'h0003;
    step();
    ram_avalid = 1'b0;
    step();
    step();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, wf_rd, mem_we, mem_re, rf_wr, err_overflow} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_strobes got=%b want=000000", {busy, wf_rd, mem_we, mem_re, rf_wr, err_overflow});
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (busy !== 1'b0 || mem_we !== 1'b0 || wf_rd !== 1'b0 || mem_re !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_quiet got active_cycles=%0d want=0", bad);
    end
    checks++;
    if (sram[15'h000C] !== 16'h7000 || sram[15'h000D] !== 16'h7001 ||
        sram[15'h000E] !== 16'h0000 || sram[15'h000F] !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_sram got=%h %h %h %h want=7000 7001 0000 0000",
               sram[15'h000C], sram[15'h000D], sram[15'h000E], sram[15'h000F]);
    end
    wf_wp = wf_rp;
    test_read_line(13'h0008, 16'h00A0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    ram_avalid = 1'b0;
    ram_addr   = '0;
    ram_rnw    = 1'b0;
    rf_full    = 1'b0;
    test_reset();
    test_write_line();
    test_read_line(13'h0008, 16'h00A0);
    test_write_starvation();
    test_read_backpressure();
    test_overflow();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
